// File: rtl/mmio_uart_tx_if.sv
// Core data-memory port as seen by an MMIO responder: MemWrite qualifies the
// store, the responder is always ready, and reads are combinational in-cycle.
interface mmio_uart_tx_if;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        Hit;

   modport master (
      output MemWrite, DataAdr, WriteData,
      input  ReadData, Hit
   );

   modport slave (
      input  MemWrite, DataAdr, WriteData,
      output ReadData, Hit
   );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: word stores to TXDATA queue bytes in a
// small FIFO, a serializer FSM shifts them out, STATUS reads back FIFO/FSM state.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   mmio_uart_tx_if.slave        bus,
   output logic                 tx,
   output logic [1:0]           dbg_state_o
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   // ---------------------------------------------------------------
   // Bus decode
   // ---------------------------------------------------------------
   logic hit;
   logic sel_status;
   logic push;
   logic clr_ovf;

   assign hit        = (bus.DataAdr[31:3] == BASE_ADDR[31:3]);
   assign sel_status = bus.DataAdr[2];
   assign push       = hit && bus.MemWrite && !sel_status;
   assign clr_ovf    = hit && bus.MemWrite && sel_status && bus.WriteData[3];

   logic unused_bits;
   assign unused_bits = ^{bus.DataAdr[1:0], bus.WriteData[31:8]};

   // ---------------------------------------------------------------
   // TX FIFO
   // ---------------------------------------------------------------
   logic [7:0]       fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             full;
   logic             empty;
   logic             pop;
   logic             accept;
   logic [7:0]       fifo_head;

   assign full      = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty     = (count_q == '0);
   assign fifo_head = fifo_mem_q[rd_ptr_q];
   // A pop in the same cycle frees the slot the push lands in.
   assign accept    = push && (!full || pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNT_W'(accept) - CNT_W'(pop);
      ovf_d    = ovf_q;
      if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && full && !pop) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) fifo_mem_q[wr_ptr_q] <= bus.WriteData[7:0];
   end

   // ---------------------------------------------------------------
   // Serializer FSM
   // ---------------------------------------------------------------
   state_t            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              baud_last;
   logic              busy;

   assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      unique case (state_q)
         S_IDLE: begin
            if (!empty) begin
               state_d = S_START;
               baud_d  = '0;
               shift_d = fifo_head;
            end
         end
         S_START: begin
            if (baud_last) begin
               state_d = S_DATA;
               baud_d  = '0;
               bit_d   = '0;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         S_DATA: begin
            if (baud_last) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = S_STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         S_STOP: begin
            // Chain straight into the next start bit when more data waits.
            if (baud_last) begin
               baud_d = '0;
               if (!empty) begin
                  state_d = S_START;
                  shift_d = fifo_head;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pop  = !empty && ((state_q == S_IDLE) || (state_q == S_STOP && baud_last));
      busy = (state_q != S_IDLE);
      tx_d = 1'b1;
      if (state_d == S_START)     tx_d = 1'b0;
      else if (state_d == S_DATA) tx_d = shift_d[0];
   end

   assign tx          = tx_q;
   assign dbg_state_o = state_q;

   // ---------------------------------------------------------------
   // Read path
   // ---------------------------------------------------------------
   logic [3:0]  count_sat;
   logic [31:0] status;

   always_comb begin
      count_sat = 4'hF;
      if (32'(count_q) < 32'd16) count_sat = 4'(count_q);
   end

   assign status       = {24'h0, count_sat, ovf_q, empty, full, busy};
   assign bus.ReadData = (hit && sel_status) ? status : 32'h0;
   assign bus.Hit      = hit;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized and directed bench for mmio_uart_tx against a cycle-count model
// of the FIFO and frame timing, plus a frame decoder feeding a byte scoreboard.
module tb_mmio_uart_tx;
   localparam logic [31:0] BASE  = 32'h0000_0100;
   localparam int          CPB   = 4;
   localparam int          DEPTH = 4;
   localparam int          FRAME = 10 * CPB;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       reset;
   logic       tx;
   logic [1:0] dbg_state;

   always #5 clk = ~clk;

   mmio_uart_tx_if bus ();

   mmio_uart_tx #(
      .BASE_ADDR    (BASE),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .tx          (tx),
      .dbg_state_o (dbg_state)
   );

   // ---------------- reference model ----------------
   // rem = cycles left in the frame on the line (0 = line idle).
   logic [7:0] mq[$];
   logic [7:0] exp_q[$];
   logic       ovf_m = 1'b0;
   int         rem = 0;
   logic [7:0] cur = 8'h00;
   int         checks = 0;
   int         errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_status();
      int n;
      int sat;
      n   = mq.size();
      sat = (n > 15) ? 15 : n;
      return (32'(sat) << 4) | (32'(ovf_m) << 3) | ((n == 0) ? 32'h4 : 32'h0) |
             ((n == DEPTH) ? 32'h2 : 32'h0) | ((rem != 0) ? 32'h1 : 32'h0);
   endfunction

   function automatic logic model_tx();
      int b;
      if (rem == 0) return 1'b1;
      b = (FRAME - rem) / CPB;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return cur[b-1];
   endfunction

   function automatic void model_edge(input logic rst, input logic we,
                                      input logic [31:0] adr, input logic [31:0] wd);
      logic in_win, push, clr, do_pop, full;
      if (rst) begin
         mq.delete();
         exp_q.delete();
         ovf_m = 1'b0;
         rem   = 0;
         return;
      end
      in_win = (adr >= BASE) && (adr < BASE + 32'd8);
      push   = we && in_win && (adr < BASE + 32'd4);
      clr    = we && in_win && (adr >= BASE + 32'd4) && wd[3];
      do_pop = (rem <= 1) && (mq.size() > 0);
      full   = (mq.size() == DEPTH);
      if (push && full && !do_pop) ovf_m = 1'b1;
      else if (clr)                ovf_m = 1'b0;
      if (do_pop) begin
         cur = mq.pop_front();
         exp_q.push_back(cur);
         rem = FRAME;
      end else if (rem > 0) begin
         rem--;
      end
      if (push && (!full || do_pop)) mq.push_back(wd[7:0]);
   endfunction

   // ---------------- driver tasks ----------------
   // Entered just after a rising edge: drive, check at the falling edge, then
   // advance the model across the next rising edge.
   task automatic tick(input logic rst, input logic we, input logic [31:0] adr, input logic [31:0] wd);
      logic        exp_hit;
      logic [31:0] exp_rd;
      reset         = rst;
      bus.MemWrite  = we;
      bus.DataAdr   = adr;
      bus.WriteData = wd;
      @(negedge clk);
      exp_hit = (adr >= BASE) && (adr < BASE + 32'd8);
      exp_rd  = (exp_hit && adr >= BASE + 32'd4) ? model_status() : 32'h0;
      check("hit", 32'(bus.Hit), 32'(exp_hit));
      check("read_data", bus.ReadData, exp_rd);
      check("tx", 32'(tx), 32'(model_tx()));
      check("dbg_busy", 32'(dbg_state != 2'd0), 32'(rem != 0));
      @(posedge clk);
      model_edge(rst, we, adr, wd);
      #1;
   endtask

   task automatic store(input logic [31:0] adr, input logic [31:0] wd);
      tick(1'b0, 1'b1, adr, wd);
   endtask

   task automatic read(input logic [31:0] adr);
      tick(1'b0, 1'b0, adr, $urandom);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((rem != 0 || mq.size() != 0) && guard < 2000) begin
         read(BASE + 32'd4);
         guard++;
      end
      check("drain_timeout", 32'(guard < 2000), 32'd1);
      repeat (3) read(BASE + 32'd4);
   endtask

   // ---------------- scoreboard: frame decoder ----------------
   initial begin : monitor
      logic [7:0] data;
      logic       s0, s9;
      bit         aborted;
      int         b;
      data = 8'h00;
      s0   = 1'b0;
      s9   = 1'b0;
      forever begin
         @(negedge clk);
         if (reset !== 1'b0 || tx !== 1'b0) continue;
         aborted = 1'b0;
         for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            if (reset !== 1'b0) aborted = 1'b1;
            if (i % CPB == CPB / 2) begin
               b = i / CPB;
               if (b == 0)      s0 = tx;
               else if (b == 9) s9 = tx;
               else             data[b-1] = tx;
            end
         end
         if (!aborted) begin
            check("frame_start_stop", 32'({s0, s9}), 32'h1);
            check("frame_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("frame_data", 32'(data), 32'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- directed + random stimulus ----------------
   logic [31:0] addr_tab [6];

   initial begin
      addr_tab[0] = 32'h0000_00FC;
      addr_tab[1] = 32'h0000_0100;
      addr_tab[2] = 32'h0000_0104;
      addr_tab[3] = 32'h0000_0106;
      addr_tab[4] = 32'h0000_0108;
      addr_tab[5] = 32'h0000_0200;

      reset         = 1'b1;
      bus.MemWrite  = 1'b1;
      bus.DataAdr   = BASE;
      bus.WriteData = 32'h0000_00A5;
      @(posedge clk);
      #1;

      // Reset held two edges with a store on the bus: nothing is queued.
      tick(1'b1, 1'b1, BASE, 32'h0000_00A5);
      read(BASE + 32'd4);
      check("reset_status", bus.ReadData, 32'h0000_0004);
      read(BASE + 32'd4);

      // Single byte.
      store(BASE, 32'h0000_00A5);
      drain();

      // Back-to-back frames.
      store(BASE, 32'h0000_0055);
      store(BASE, 32'h0000_000F);
      drain();

      // Overflow: six consecutive stores, then clear.
      for (int i = 0; i < 6; i++) store(BASE, $urandom);
      read(BASE + 32'd4);
      store(BASE + 32'd4, 32'h0000_0008);
      read(BASE + 32'd4);
      drain();

      // Decode corners.
      read(32'h0000_0108);
      read(32'h0000_00FC);
      store(32'h0000_00FC, 32'h0000_0033);
      store(32'h0000_0103, 32'hFFFF_FF3C);
      read(32'h0000_0106);
      drain();

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         int r;
         r = $urandom_range(0, 15);
         case (r)
            0, 1:    store(BASE + 32'($urandom_range(0, 3)), $urandom);
            2:       store(BASE + 32'd4 + 32'($urandom_range(0, 3)), $urandom);
            3:       store(addr_tab[$urandom_range(0, 5)], $urandom);
            default: read(addr_tab[$urandom_range(0, 5)]);
         endcase
      end
      drain();

      // Reset mid-frame with two bytes still queued.
      store(BASE, $urandom);
      store(BASE, $urandom);
      store(BASE, $urandom);
      repeat (17) read(BASE + 32'd4);
      tick(1'b1, 1'b0, BASE + 32'd4, 32'h0);
      read(BASE + 32'd4);
      check("midframe_reset_status", bus.ReadData, 32'h0000_0004);
      repeat (FRAME + 20) read(BASE + 32'd4);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
